// File: rtl/snn_pkg.sv
// Shared definitions for the SNN input path.
// Holds the frame geometry used by image_loader and snn_core, and the
// loader FSM state type.
package snn_pkg;

  localparam int NUM_INPUT_BITS  = 784;
  localparam int INPUT_ADDR_W    = 10;
  localparam int BYTES_PER_FRAME = 98;

  typedef enum logic [1:0] {
    RECV      = 2'd0,
    UNPACK    = 2'd1,
    WAIT_CORE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/image_loader_idle_timer.sv
// Inter-byte idle timer for image_loader.
// Down-counter loaded with TIMEOUT_CYC; counts enabled cycles and raises
// expire during the enabled cycle that reaches the terminal count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the counter (wins over en)
//   en         : count this cycle
//   expire     : combinational one-cycle pulse on the TIMEOUT_CYC-th enabled cycle
module idle_timer #(
  parameter int TIMEOUT_CYC = 5000000,
  parameter int TO_W        = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LOAD = TO_W'(TIMEOUT_CYC);

  logic [TO_W-1:0] cnt;

  assign expire = en && !clr && (cnt == TO_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clr || expire) begin
      cnt <= LOAD;
    end else if (en) begin
      cnt <= cnt - TO_W'(1);
    end
  end

endmodule

// File: rtl/image_loader.sv
// image_loader: unpacks UART bytes into 1-bit writes of the input RAM and
// hands a complete frame to snn_core.
//   clk, rst_n       : clock, asynchronous active-low reset
//   rx_rdy, rx_data  : received byte strobe and data
//   core_done        : classification finished pulse from snn_core
//   ram_we/addr/data : input RAM write port, byte k bit i -> address 8k+i
//   start            : one-cycle pulse once the whole frame is written
//   busy             : high from start until core_done
//   bytes_rcvd       : bytes accepted into the current frame
//   err_timeout      : pulse when an idle partial frame is discarded
//   overrun          : sticky dropped-byte flag, cleared on start
//
// state     | meaning
// RECV      | idle / between bytes; takes the held byte or a new rx byte
// UNPACK    | writing the 8 bits of the current byte, LSB first
// WAIT_CORE | frame handed off; incoming bytes are dropped until core_done
module image_loader
  import snn_pkg::*;
#(
  parameter int NUM_BITS    = NUM_INPUT_BITS,
  parameter int ADDR_W      = INPUT_ADDR_W,
  parameter int TIMEOUT_CYC = 5000000,
  parameter int TO_W        = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              core_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              start,
  output logic              busy,
  output logic [6:0]        bytes_rcvd,
  output logic              err_timeout,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_BITS);

  loader_state_t     state, state_d;
  logic [7:0]        shift, shift_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [ADDR_W-1:0] bit_ptr, bit_ptr_d;
  logic              hold_full, hold_full_d;
  logic [7:0]        hold_data, hold_data_d;
  logic [6:0]        bytes_d;
  logic              overrun_d, busy_d, start_d, err_d;
  logic              ram_we_d, ram_data_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [7:0]        byte_in;
  logic              timer_en, timer_clr, timer_expire;

  assign byte_in   = hold_full ? hold_data : rx_data;
  assign timer_en  = (state == RECV) && (bytes_rcvd != 7'd0) && !hold_full;
  assign timer_clr = rx_rdy || !timer_en;

  idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .expire(timer_expire)
  );

  always_comb begin
    state_d     = state;
    shift_d     = shift;
    bit_cnt_d   = bit_cnt;
    bit_ptr_d   = bit_ptr;
    hold_full_d = hold_full;
    hold_data_d = hold_data;
    bytes_d     = bytes_rcvd;
    overrun_d   = overrun;
    busy_d      = busy;
    start_d     = 1'b0;
    err_d       = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_data_d  = ram_data;

    case (state)
      RECV: begin
        if (hold_full || rx_rdy) begin
          // Bit 0 is written on the capture edge so the 8 writes land in the
          // 8 cycles following rx_rdy.
          ram_we_d   = 1'b1;
          ram_addr_d = bit_ptr;
          ram_data_d = byte_in[0];
          shift_d    = {1'b0, byte_in[7:1]};
          bit_ptr_d  = bit_ptr + ADDR_W'(1);
          bit_cnt_d  = 3'd1;
          bytes_d    = bytes_rcvd + 7'd1;
          state_d    = UNPACK;
          if (hold_full) begin
            hold_full_d = rx_rdy;
            if (rx_rdy) hold_data_d = rx_data;
          end
        end else if (timer_expire) begin
          bit_ptr_d = '0;
          bytes_d   = 7'd0;
          err_d     = 1'b1;
        end
      end

      UNPACK: begin
        if (rx_rdy) begin
          if (!hold_full) begin
            hold_full_d = 1'b1;
            hold_data_d = rx_data;
          end else begin
            overrun_d = 1'b1;
          end
        end
        if (bit_cnt != 3'd0) begin
          ram_we_d   = 1'b1;
          ram_addr_d = bit_ptr;
          ram_data_d = shift[0];
          shift_d    = {1'b0, shift[7:1]};
          bit_ptr_d  = bit_ptr + ADDR_W'(1);
          bit_cnt_d  = bit_cnt + 3'd1;
        end else if (bit_ptr == LAST_PTR) begin
          start_d     = 1'b1;
          busy_d      = 1'b1;
          bit_ptr_d   = '0;
          bytes_d     = 7'd0;
          // Any byte still held or arriving now is lost by the flush, so it
          // re-arms the flag that start otherwise clears.
          overrun_d   = rx_rdy || hold_full;
          hold_full_d = 1'b0;
          state_d     = WAIT_CORE;
        end else begin
          state_d = RECV;
        end
      end

      WAIT_CORE: begin
        if (rx_rdy) overrun_d = 1'b1;
        if (core_done) begin
          busy_d  = 1'b0;
          state_d = RECV;
        end
      end

      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RECV;
      shift       <= '0;
      bit_cnt     <= '0;
      bit_ptr     <= '0;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      bytes_rcvd  <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      start       <= 1'b0;
      err_timeout <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= 1'b0;
    end else begin
      state       <= state_d;
      shift       <= shift_d;
      bit_cnt     <= bit_cnt_d;
      bit_ptr     <= bit_ptr_d;
      hold_full   <= hold_full_d;
      hold_data   <= hold_data_d;
      bytes_rcvd  <= bytes_d;
      overrun     <= overrun_d;
      busy        <= busy_d;
      start       <= start_d;
      err_timeout <= err_d;
      ram_we      <= ram_we_d;
      ram_addr    <= ram_addr_d;
      ram_data    <= ram_data_d;
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with a shortened idle timeout.
module tb_image_loader;
  import snn_pkg::*;

  localparam int TO  = 1000;
  localparam int GAP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       core_done = 1'b0;
  logic       ram_we, ram_data, start, busy, err_timeout, overrun;
  logic [INPUT_ADDR_W-1:0] ram_addr;
  logic [6:0] bytes_rcvd;

  image_loader #(
    .NUM_BITS   (NUM_INPUT_BITS),
    .ADDR_W     (INPUT_ADDR_W),
    .TIMEOUT_CYC(TO),
    .TO_W       (23)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .core_done  (core_done),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .start      (start),
    .busy       (busy),
    .bytes_rcvd (bytes_rcvd),
    .err_timeout(err_timeout),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Edge counter; a byte sampled at edge c has its writes visible after
  // edges c..c+7 and, for the last byte, start after edge c+8.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] wq[$];
  int start_cnt = 0, start_cyc = 0, err_cnt = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) wq.push_back({ram_data, ram_addr});
      if (start) begin
        start_cnt <= start_cnt + 1;
        start_cyc <= cyc;
      end
      if (err_timeout) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
    end
  end

  int checks = 0, errors = 0;
  int last_rx = 0;
  logic [7:0] exp_bytes [BYTES_PER_FRAME];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge clk);
    #1 rx_rdy = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 last_rx = cyc;
    rx_rdy = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      pulse_rx(exp_bytes[k]);
      idle(GAP);
    end
  endtask

  task automatic check_frame(input string tag, input int base);
    int bad = 0;
    chk({tag, "_count"}, wq.size() - base, NUM_INPUT_BITS);
    for (int i = 0; i < NUM_INPUT_BITS; i++) begin
      if (base + i >= wq.size()) bad++;
      else if (wq[base + i] !== {exp_bytes[i / 8][i % 8], 10'(i)}) bad++;
    end
    chk({tag, "_data"}, bad, 0);
  endtask

  task automatic wait_err(input string tag, input int base);
    for (int i = 0; i < TO + 100 && err_cnt == base; i++) @(negedge clk);
    chk(tag, err_cnt, base + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, sb, eb;
    logic [7:0] v;

    // Reset
    idle(3);
    #1;
    chk("reset_flags", {26'd0, ram_we, start, busy, err_timeout, overrun, ram_data}, 0);
    chk("reset_bytes", bytes_rcvd, 0);
    chk("reset_addr", ram_addr, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: full frame of 0xA5
    for (int k = 0; k < BYTES_PER_FRAME; k++) exp_bytes[k] = 8'hA5;
    wb = wq.size();
    sb = start_cnt;
    send_range(0, 50);
    chk("t1_bytes_mid", bytes_rcvd, 50);
    send_range(50, BYTES_PER_FRAME);
    idle(4);
    check_frame("t1_frame", wb);
    for (int i = 0; i < 8; i++) v[i] = wq[wb + i][10];
    chk("t1_bits0_7", v, 8'hA5);
    chk("t1_addr783", wq[wb + 783], {1'b1, 10'd783});
    chk("t1_start_cnt", start_cnt - sb, 1);
    chk("t1_start_lat", start_cyc - last_rx, 8);
    chk("t1_busy", busy, 1);
    chk("t1_bytes_end", bytes_rcvd, 0);
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    idle(2);
    chk("t1_busy_clr", busy, 0);

    // 2: two bytes 3 cycles apart
    wb = wq.size();
    pulse_rx(8'h01);
    idle(1);
    pulse_rx(8'h80);
    idle(30);
    chk("t2_count", wq.size() - wb, 16);
    v = 8'd0;
    for (int i = 0; i < 16; i++) begin
      if (wq[wb + i][9:0] !== 10'(i)) v[0] = 1'b1;
      if (wq[wb + i][10] !== ((i == 0) || (i == 15))) v[1] = 1'b1;
    end
    chk("t2_pattern", v, 0);
    chk("t2_overrun", overrun, 0);
    eb = err_cnt;
    wait_err("t2_timeout", eb);

    // 3: three bytes inside one unpack window
    idle(2);
    wb = wq.size();
    pulse_rx(8'h11);
    pulse_rx(8'h22);
    pulse_rx(8'h33);
    idle(30);
    chk("t3_count", wq.size() - wb, 16);
    chk("t3_overrun", overrun, 1);
    chk("t3_bytes", bytes_rcvd, 2);
    eb = err_cnt;
    wait_err("t3_timeout", eb);

    // 4: partial frame timeout then a clean frame
    idle(2);
    for (int k = 0; k < BYTES_PER_FRAME; k++) exp_bytes[k] = 8'(k);
    send_range(0, 10);
    chk("t4_bytes10", bytes_rcvd, 10);
    eb = err_cnt;
    wait_err("t4_timeout", eb);
    idle(2);
    chk("t4_to_latency", err_cyc - last_rx, 1008);
    chk("t4_bytes_clr", bytes_rcvd, 0);
    wb = wq.size();
    sb = start_cnt;
    send_range(0, BYTES_PER_FRAME);
    idle(4);
    check_frame("t4_frame", wb);
    chk("t4_start_cnt", start_cnt - sb, 1);
    chk("t4_overrun_clr", overrun, 0);

    // 5: bytes while busy
    wb = wq.size();
    pulse_rx(8'h55);
    idle(12);
    chk("t5_busy_writes", wq.size() - wb, 0);
    chk("t5_busy_overrun", overrun, 1);
    chk("t5_busy_held", busy, 1);
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    idle(2);
    for (int k = 0; k < BYTES_PER_FRAME; k++) exp_bytes[k] = 8'(k * 7 + 3);
    wb = wq.size();
    sb = start_cnt;
    send_range(0, BYTES_PER_FRAME);
    idle(4);
    check_frame("t5_frame", wb);
    chk("t5_start_cnt", start_cnt - sb, 1);
    chk("t5_overrun_clr", overrun, 0);
    wb = wq.size();
    @(posedge clk); #1 rx_rdy = 1'b1; core_done = 1'b1; rx_data = 8'hFF;
    @(posedge clk); #1 rx_rdy = 1'b0; core_done = 1'b0;
    idle(20);
    chk("t5_same_writes", wq.size() - wb, 0);
    chk("t5_same_overrun", overrun, 1);
    chk("t5_same_busy", busy, 0);
    chk("t5_same_bytes", bytes_rcvd, 0);

    // 6: reset mid-frame, then a full frame
    for (int k = 0; k < BYTES_PER_FRAME; k++) exp_bytes[k] = 8'h3C;
    send_range(0, 50);
    chk("t6_bytes_mid", bytes_rcvd, 50);
    @(posedge clk); #1 rst_n = 1'b0;
    idle(2);
    #1;
    chk("t6_rst_flags", {26'd0, ram_we, start, busy, err_timeout, overrun, ram_data}, 0);
    chk("t6_rst_bytes", bytes_rcvd, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
    wb = wq.size();
    sb = start_cnt;
    send_range(0, BYTES_PER_FRAME);
    idle(4);
    check_frame("t6_frame", wb);
    chk("t6_start_cnt", start_cnt - sb, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
Upstream stage of snn_core. It takes synchronized UART bytes (rx_rdy/rx_data from uart_rx) and unpacks each byte into eight 1-bit writes to the 784x1 input RAM. After the full 98-byte frame is stored, it pulses start to snn_core. It then blocks new frames until snn_core signals done, and recovers from aborted or partial frames with an inter-byte timeout.

Parameters:
NUM_BITS, 784, number of input bits per frame; must be a multiple of 8.
ADDR_W, 10, RAM address width.
TIMEOUT_CYC, 5000000, idle cycles allowed between bytes of a partial frame (100 ms at 50 MHz).
TO_W, 23, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
clk  in  1  50 MHz system clock.
rst_n  in  1  Reset, asynchronous, active-low.
rx_rdy  in  1  One-cycle pulse; rx_data is valid.
rx_data  in  8  Received byte.
core_done  in  1  One-cycle pulse from snn_core when classification is finished.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM write address.
ram_data  out  1  RAM write bit.
start  out  1  One-cycle pulse to snn_core.
busy  out  1  High from start until core_done.
bytes_rcvd  out  7  Bytes of the current frame accepted so far (0..98).
err_timeout  out  1  One-cycle pulse when a partial frame is discarded.
overrun  out  1  Sticky; set when a byte is dropped. Cleared by reset or by the next start pulse.

Behaviour:
- Reset (clk, rst_n asynchronous, active-low): state=RECV; bit_ptr=0; hold register empty; all outputs 0. RAM contents are not cleared.
- All outputs are registered.
- States: RECV, UNPACK, WAIT_CORE.
- RECV:
  - rx_rdy with hold empty: capture rx_data into the shift register, bytes_rcvd+1, go to UNPACK.
  - If the hold register is full, take the held byte instead, without waiting for rx_rdy.
- UNPACK:
  - 8 consecutive cycles with ram_we=1, ram_data=shift[0] (LSB first), ram_addr=bit_ptr. Shift right and increment bit_ptr each cycle.
  - Mapping: byte k, bit i -> address 8k+i.
  - rx_rdy during UNPACK: byte goes into a one-deep hold register. If hold is already full, drop the byte and set overrun.
  - After the 8th write:
    - bit_ptr==NUM_BITS: pulse start, busy=1, bit_ptr=0, bytes_rcvd=0, clear overrun, go to WAIT_CORE.
    - Otherwise: return to RECV.
- WAIT_CORE:
  - rx_rdy is dropped and sets overrun. This includes rx_rdy in the same cycle as core_done.
  - The hold register is flushed on entry.
  - core_done: busy=0, go to RECV.
- Latency: rx_rdy at cycle N -> writes at N+1..N+8. For the last byte, start is asserted at N+9, so all RAM writes complete before start.
- Timeout:
  - The counter runs only in RECV with bytes_rcvd!=0 and hold empty.
  - It clears on rx_rdy.
  - On reaching TIMEOUT_CYC: bit_ptr=0, bytes_rcvd=0, pulse err_timeout. Partially written RAM data is left in place.
  - No timeout in UNPACK or WAIT_CORE.
- core_done outside WAIT_CORE is ignored.
- Reset mid-frame or mid-core: returns to RECV with an empty frame. No start pulse is generated.
- bit_ptr never exceeds NUM_BITS; no wrap occurs because the frame end is detected explicitly.

Decomposition:
- Package snn_pkg holds:
  - localparams NUM_INPUT_BITS=784, INPUT_ADDR_W=10, BYTES_PER_FRAME=98.
  - typedef enum loader_state_t {RECV, UNPACK, WAIT_CORE}.
- One sub-module: idle_timer (load/clear, enable, expire pulse) for the inter-byte timeout.
- Shift/hold logic stays inline.

Test Plan:
1. Send 98 bytes 0xA5 spaced 5000 cycles apart -> 784 writes; addr 0..7 data 1,0,1,0,0,1,0,1; addr 783 data 1; one start pulse 9 cycles after the 98th rx_rdy; busy=1; bytes_rcvd returns to 0.
2. Two rx_rdy pulses 3 cycles apart (0x01 then 0x80) -> 16 contiguous writes: addr 0 =1, addr 15 =1, all others 0; overrun stays 0.
3. Three rx_rdy pulses within 8 cycles -> third byte dropped, overrun=1, exactly 16 writes.
4. 10 bytes then silence (TIMEOUT_CYC reduced to 1000) -> err_timeout pulse at 1000 idle cycles, bytes_rcvd=0; the next 98-byte frame starts writing at addr 0.
5. rx_rdy while busy, including the same cycle as core_done -> no RAM writes, overrun=1; after core_done, a new frame loads normally and overrun clears at its start.
6. Assert rst_n low after byte 50, then send a full frame -> outputs 0 during reset; writes restart at addr 0; exactly one start pulse.
